// File: rtl/uart_alu_interface_if.sv
// Signal bundle between the UART frame controller and its receiver, ALU and transmitter.
// The master side is the frame controller; the slave side is the surrounding datapath.
interface uart_alu_interface_if #(
   parameter int N_BIT = 8,
   parameter int N_OP  = 6
);
   logic             rx_done;
   logic [N_BIT-1:0] rx_data;
   logic [N_BIT-1:0] alu_result;
   logic             tx_done;
   logic [N_BIT-1:0] alu_a;
   logic [N_BIT-1:0] alu_b;
   logic [N_OP-1:0]  alu_op;
   logic [N_BIT-1:0] tx_data;
   logic             tx_start;
   logic             tout;
   logic [2:0]       state;

   modport master (
      input  rx_done, rx_data, alu_result, tx_done,
      output alu_a, alu_b, alu_op, tx_data, tx_start, tout, state
   );

   modport slave (
      output rx_done, rx_data, alu_result, tx_done,
      input  alu_a, alu_b, alu_op, tx_data, tx_start, tout, state
   );
endinterface

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode from the UART receiver, drives a combinational
// ALU with registered operands and returns the result through the transmitter.
module uart_alu_interface #(
   parameter int N_BIT   = 8,
   parameter int N_OP    = 6,
   parameter int TIMEOUT = 1000000
) (
   input logic                 CLK,
   input logic                 RESET,
   uart_alu_interface_if.master bus
);

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      SEND    = 3'd3,
      WAIT_TX = 3'd4
   } state_t;

   localparam logic [19:0] TERM_COUNT = (TIMEOUT == 0) ? 20'd0 : 20'(TIMEOUT - 1);
   localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

   state_t           state_reg, state_next;
   logic [N_BIT-1:0] alu_a_reg, alu_a_next;
   logic [N_BIT-1:0] alu_b_reg, alu_b_next;
   logic [N_OP-1:0]  alu_op_reg, alu_op_next;
   logic [N_BIT-1:0] tx_data_reg, tx_data_next;
   logic             tx_start_reg, tx_start_next;
   logic             tout_reg, tout_next;
   logic [19:0]      cnt_reg, cnt_next;
   logic             timeout_hit;

   assign timeout_hit = TIMEOUT_EN && (cnt_reg == TERM_COUNT);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg    <= WAIT_A;
         alu_a_reg    <= '0;
         alu_b_reg    <= '0;
         alu_op_reg   <= '0;
         tx_data_reg  <= '0;
         tx_start_reg <= 1'b0;
         tout_reg     <= 1'b0;
         cnt_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         alu_a_reg    <= alu_a_next;
         alu_b_reg    <= alu_b_next;
         alu_op_reg   <= alu_op_next;
         tx_data_reg  <= tx_data_next;
         tx_start_reg <= tx_start_next;
         tout_reg     <= tout_next;
         cnt_reg      <= cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      alu_a_next    = alu_a_reg;
      alu_b_next    = alu_b_reg;
      alu_op_next   = alu_op_reg;
      tx_data_next  = tx_data_reg;
      tx_start_next = 1'b0;
      tout_next     = 1'b0;
      cnt_next      = cnt_reg;
      case (state_reg)
         WAIT_A: begin
            if (bus.rx_done) begin
               alu_a_next = bus.rx_data;
               cnt_next   = '0;
               state_next = WAIT_B;
            end
         end
         WAIT_B: begin
            // An arriving byte takes priority over a terminal count in the same cycle.
            if (bus.rx_done) begin
               alu_b_next = bus.rx_data;
               cnt_next   = '0;
               state_next = WAIT_OP;
            end else if (timeout_hit) begin
               tout_next  = 1'b1;
               cnt_next   = '0;
               state_next = WAIT_A;
            end else begin
               cnt_next = cnt_reg + 20'd1;
            end
         end
         WAIT_OP: begin
            if (bus.rx_done) begin
               alu_op_next = bus.rx_data[N_OP-1:0];
               cnt_next    = '0;
               state_next  = SEND;
            end else if (timeout_hit) begin
               tout_next  = 1'b1;
               cnt_next   = '0;
               state_next = WAIT_A;
            end else begin
               cnt_next = cnt_reg + 20'd1;
            end
         end
         SEND: begin
            // ALU_OP has been stable for a full cycle, so the result is settled here.
            tx_data_next  = bus.alu_result;
            tx_start_next = 1'b1;
            state_next    = WAIT_TX;
         end
         WAIT_TX: begin
            if (bus.tx_done) begin
               state_next = WAIT_A;
            end
         end
         default: state_next = WAIT_A;
      endcase
   end

   assign bus.alu_a    = alu_a_reg;
   assign bus.alu_b    = alu_b_reg;
   assign bus.alu_op   = alu_op_reg;
   assign bus.tx_data  = tx_data_reg;
   assign bus.tx_start = tx_start_reg;
   assign bus.tout     = tout_reg;
   assign bus.state    = state_reg;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: table of frames plus hand-written timeout, race,
// dropped-byte and reset sequences; expected ALU results flow through a queue.
module tb_uart_alu_interface;
   localparam int N_BIT = 8;
   localparam int N_OP  = 6;
   localparam int TO    = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_alu_interface_if #(.N_BIT(N_BIT), .N_OP(N_OP)) bus ();

   uart_alu_interface #(.N_BIT(N_BIT), .N_OP(N_OP), .TIMEOUT(TO)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   // External ALU model: 0x20 add, 0x22 subtract, anything else xor.
   always_comb begin
      case (bus.alu_op)
         6'h20:   bus.alu_result = bus.alu_a + bus.alu_b;
         6'h22:   bus.alu_result = bus.alu_a - bus.alu_b;
         default: bus.alu_result = bus.alu_a ^ bus.alu_b;
      endcase
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] opb;
      logic [5:0] eop;
      logic [7:0] eres;
   } vec_t;

   vec_t       vecs [5];
   logic [7:0] exp_q [$];
   int         checks = 0;
   int         passed = 0;
   int         frames_started = 0;

   int   tx_start_pulses = 0;
   int   tout_pulses = 0;
   int   wide_pulses = 0;
   logic prev_start = 1'b0;
   logic prev_tout = 1'b0;

   always @(negedge clk) begin
      if (bus.tx_start && !prev_start) tx_start_pulses <= tx_start_pulses + 1;
      if (bus.tout && !prev_tout) tout_pulses <= tout_pulses + 1;
      if ((bus.tx_start && prev_start) || (bus.tout && prev_tout)) wide_pulses <= wide_pulses + 1;
      prev_start <= bus.tx_start;
      prev_tout  <= bus.tout;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      tick();
      bus.rx_done = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_state"}, 32'(bus.state), 32'd0);
      check({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
      check({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
      check({tag, "_alu_op"}, 32'(bus.alu_op), 32'd0);
      check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
      check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
      check({tag, "_tout"}, 32'(bus.tout), 32'd0);
   endtask

   // Sends the opcode, waits (bounded) for TX_START, scores TX_DATA; ends in WAIT_TX.
   task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input logic [5:0] eop, input logic [7:0] eres);
      int n;
      exp_q.push_back(eres);
      frames_started++;
      send_byte(opb);
      check("alu_a", 32'(bus.alu_a), 32'(a));
      check("alu_b", 32'(bus.alu_b), 32'(b));
      check("alu_op", 32'(bus.alu_op), 32'(eop));
      check("state_send", 32'(bus.state), 32'd3);
      n = 0;
      while (!bus.tx_start && n < 8) begin
         tick();
         n++;
      end
      check("start_latency", 32'(n), 32'd1);
      check("tx_start", 32'(bus.tx_start), 32'd1);
      check("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      tick();
      check("tx_start_end", 32'(bus.tx_start), 32'd0);
      check("state_wait_tx", 32'(bus.state), 32'd4);
   endtask

   task automatic finish_tx(input logic [7:0] eres);
      tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      check("state_after_tx", 32'(bus.state), 32'd0);
      check("tx_data_hold", 32'(bus.tx_data), 32'(eres));
   endtask

   task automatic run_frame(input vec_t v);
      send_byte(v.a);
      send_byte(v.b);
      send_op(v.a, v.b, v.opb, v.eop, v.eres);
      finish_tx(v.eres);
   endtask

   initial begin
      vecs[0] = '{a: 8'h05, b: 8'h03, opb: 8'h20, eop: 6'h20, eres: 8'h08};
      vecs[1] = '{a: 8'h10, b: 8'h04, opb: 8'hE2, eop: 6'h22, eres: 8'h0C};
      vecs[2] = '{a: 8'hFF, b: 8'h01, opb: 8'h20, eop: 6'h20, eres: 8'h00};
      vecs[3] = '{a: 8'h3C, b: 8'h0F, opb: 8'h07, eop: 6'h07, eres: 8'h33};
      vecs[4] = '{a: 8'h80, b: 8'h80, opb: 8'hE0, eop: 6'h20, eres: 8'h00};

      bus.rx_done = 1'b0;
      bus.rx_data = '0;
      bus.tx_done = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_zero("reset");

      for (int i = 0; i < 5; i++) run_frame(vecs[i]);

      // Timeout: A accepted at edge e0; terminal count on edge e0+16.
      send_byte(8'hAA);
      check("to_state_b", 32'(bus.state), 32'd1);
      repeat (15) tick();
      check("to_not_yet", 32'(bus.tout), 32'd0);
      check("to_state_hold", 32'(bus.state), 32'd1);
      tick();
      check("to_tout", 32'(bus.tout), 32'd1);
      check("to_state_a", 32'(bus.state), 32'd0);
      check("to_stale_a", 32'(bus.alu_a), 32'hAA);
      tick();
      check("to_tout_end", 32'(bus.tout), 32'd0);
      run_frame('{a: 8'h01, b: 8'h01, opb: 8'h20, eop: 6'h20, eres: 8'h02});

      // Race: B arrives exactly on the terminal-count edge.
      send_byte(8'h0A);
      repeat (15) tick();
      send_byte(8'h05);
      check("race_state", 32'(bus.state), 32'd2);
      check("race_tout", 32'(bus.tout), 32'd0);
      check("race_alu_b", 32'(bus.alu_b), 32'h05);
      send_op(8'h0A, 8'h05, 8'h20, 6'h20, 8'h0F);
      finish_tx(8'h0F);

      // Dropped bytes in WAIT_TX and on the TX_DONE edge.
      send_byte(8'h09);
      send_byte(8'h09);
      send_op(8'h09, 8'h09, 8'h20, 6'h20, 8'h12);
      send_byte(8'h77);
      check("drop_state", 32'(bus.state), 32'd4);
      check("drop_alu_a", 32'(bus.alu_a), 32'h09);
      bus.tx_done = 1'b1;
      send_byte(8'h55);
      bus.tx_done = 1'b0;
      check("drop_race_state", 32'(bus.state), 32'd0);
      check("drop_race_alu_a", 32'(bus.alu_a), 32'h09);
      send_byte(8'h02);
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      check("txdone_in_b", 32'(bus.state), 32'd1);
      send_byte(8'h04);
      send_op(8'h02, 8'h04, 8'h20, 6'h20, 8'h06);
      finish_tx(8'h06);

      // Reset in WAIT_OP, then in WAIT_TX.
      send_byte(8'h11);
      send_byte(8'h22);
      check("pre_rst_state", 32'(bus.state), 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero("rst_wait_op");
      send_byte(8'h11);
      send_byte(8'h22);
      send_op(8'h11, 8'h22, 8'h20, 6'h20, 8'h33);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero("rst_wait_tx");
      run_frame('{a: 8'h21, b: 8'h12, opb: 8'h22, eop: 6'h22, eres: 8'h0F});

      tick();
      check("tx_start_pulses", 32'(tx_start_pulses), 32'(frames_started));
      check("tout_pulses", 32'(tout_pulses), 32'd1);
      check("wide_pulses", 32'(wide_pulses), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
